// File: rtl/ctrl_pkg.sv
// Shared constants, state and instruction-class types, and datapath select
// encodings for the multi-cycle MIPS main controller.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_NANDI  = 6'b010000;
  localparam logic [5:0] OP_BLEZAL = 6'b100100;
  localparam logic [5:0] OP_BALV   = 6'b100000;
  localparam logic [5:0] OP_JALPC  = 6'b011111;

  localparam logic [5:0] FN_BRV    = 6'd20;
  localparam logic [5:0] FN_JMXOR  = 6'd34;

  typedef enum logic [4:0] {
    ST_FETCH  = 5'd0,  ST_DECODE = 5'd1,  ST_MEMADR = 5'd2,  ST_MEMRD  = 5'd3,
    ST_MEMWB  = 5'd4,  ST_MEMWR  = 5'd5,  ST_RCALC  = 5'd6,  ST_RWB    = 5'd7,
    ST_JMRD   = 5'd8,  ST_JMWB   = 5'd9,  ST_BEQ    = 5'd10, ST_BLEZAL = 5'd11,
    ST_BALV   = 5'd12, ST_JALPC  = 5'd13, ST_BRV    = 5'd14, ST_ICALC  = 5'd15,
    ST_IWB    = 5'd16, ST_ILL    = 5'd17
  } state_t;

  typedef enum logic [3:0] {
    CL_LW     = 4'd0, CL_SW    = 4'd1, CL_RTYPE  = 4'd2, CL_JMXOR = 4'd3,
    CL_BRV    = 4'd4, CL_BEQ   = 4'd5, CL_NANDI  = 4'd6, CL_BLEZAL = 4'd7,
    CL_BALV   = 4'd8, CL_JALPC = 4'd9, CL_ILL    = 4'd10
  } iclass_t;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_MDR    = 2'b10;
  localparam logic [1:0] PCS_REGA   = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NAND  = 2'b11;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  function automatic logic is_ext(input iclass_t c);
    case (c)
      CL_BRV, CL_JMXOR, CL_NANDI, CL_BLEZAL, CL_BALV, CL_JALPC: is_ext = 1'b1;
      default: is_ext = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: maps opcode/funct to the class that
// steers the DECODE and RCALC transitions; extended classes fold to illegal
// when they are disabled.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int FNW    = 6,
  parameter int EXT_EN = 1
) (
  input  logic [OPW-1:0] opcode,
  input  logic [FNW-1:0] functcode,
  output iclass_t        iclass
);

  iclass_t raw_s;

  // Raw classification independent of the extension enable.
  always_comb begin
    raw_s = CL_ILL;
    case (opcode)
      OPW'(OP_RTYPE): begin
        if (functcode == FNW'(FN_BRV)) begin
          raw_s = CL_BRV;
        end else if (functcode == FNW'(FN_JMXOR)) begin
          raw_s = CL_JMXOR;
        end else begin
          raw_s = CL_RTYPE;
        end
      end
      OPW'(OP_LW):     raw_s = CL_LW;
      OPW'(OP_SW):     raw_s = CL_SW;
      OPW'(OP_BEQ):    raw_s = CL_BEQ;
      OPW'(OP_NANDI):  raw_s = CL_NANDI;
      OPW'(OP_BLEZAL): raw_s = CL_BLEZAL;
      OPW'(OP_BALV):   raw_s = CL_BALV;
      OPW'(OP_JALPC):  raw_s = CL_JALPC;
      default:         raw_s = CL_ILL;
    endcase
  end

  // Disabled extensions decode exactly like any unknown instruction.
  always_comb begin
    if (EXT_EN == 0 && is_ext(raw_s)) begin
      iclass = CL_ILL;
    end else begin
      iclass = raw_s;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: Moore sequencer over fetch/decode/execute/
// memory/write-back with memory-ready stalls and a wrapping retired counter.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int FNW    = 6,
  parameter int EXT_EN = 1,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  opcode,
  input  logic [FNW-1:0]  functcode,
  input  logic            mem_ready,
  input  logic            flag_z,
  input  logic            flag_n,
  input  logic            flag_v,
  output logic            pc_write,
  output logic            ir_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic            iord,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic [1:0]      reg_dst,
  output logic [1:0]      mem_to_reg,
  output logic            illegal_op,
  output logic            retire,
  output logic [CNTW-1:0] retired_cnt
);

  state_t          state_r, next_s;
  iclass_t         iclass_s;
  logic [CNTW-1:0] cnt_r;
  logic            link_s, retire_s;
  logic            pc_write_s, ir_write_s, mem_read_s, mem_write_s, reg_write_s;
  logic            iord_s, alu_src_a_s, illegal_s;
  logic [1:0]      alu_src_b_s, alu_op_s, pc_source_s, reg_dst_s, mem_to_reg_s;

  ctrl_decode #(.OPW(OPW), .FNW(FNW), .EXT_EN(EXT_EN)) u_decode (
    .opcode    (opcode),
    .functcode (functcode),
    .iclass    (iclass_s)
  );

  // Next-state selection; memory states hold until the handshake completes.
  always_comb begin
    next_s = ST_FETCH;
    case (state_r)
      ST_FETCH: begin
        if (mem_ready) next_s = ST_DECODE;
        else           next_s = ST_FETCH;
      end
      ST_DECODE: begin
        case (iclass_s)
          CL_LW, CL_SW:       next_s = ST_MEMADR;
          CL_RTYPE, CL_JMXOR: next_s = ST_RCALC;
          CL_BRV:             next_s = ST_BRV;
          CL_BEQ:             next_s = ST_BEQ;
          CL_NANDI:           next_s = ST_ICALC;
          CL_BLEZAL:          next_s = ST_BLEZAL;
          CL_BALV:            next_s = ST_BALV;
          CL_JALPC:           next_s = ST_JALPC;
          default:            next_s = ST_ILL;
        endcase
      end
      ST_MEMADR: begin
        if (iclass_s == CL_SW) next_s = ST_MEMWR;
        else                   next_s = ST_MEMRD;
      end
      ST_MEMRD: begin
        if (mem_ready) next_s = ST_MEMWB;
        else           next_s = ST_MEMRD;
      end
      ST_MEMWR: begin
        if (mem_ready) next_s = ST_FETCH;
        else           next_s = ST_MEMWR;
      end
      ST_RCALC: begin
        if (iclass_s == CL_JMXOR) next_s = ST_JMRD;
        else                      next_s = ST_RWB;
      end
      ST_JMRD: begin
        if (mem_ready) next_s = ST_JMWB;
        else           next_s = ST_JMRD;
      end
      ST_ICALC: next_s = ST_IWB;
      default:  next_s = ST_FETCH;
    endcase
  end

  assign link_s   = ((state_r == ST_BLEZAL) & (flag_z | flag_n)) |
                    ((state_r == ST_BALV) & flag_v) |
                    (state_r == ST_JALPC);
  assign retire_s = (next_s == ST_FETCH) && (state_r != ST_FETCH) && (state_r != ST_ILL);

  // Moore output decode plus the flag and handshake qualified strobes.
  always_comb begin
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    iord_s       = 1'b0;
    alu_src_a_s  = 1'b0;
    illegal_s    = 1'b0;
    alu_src_b_s  = SRCB_B;
    alu_op_s     = ALUOP_ADD;
    pc_source_s  = PCS_ALU;
    reg_dst_s    = RDST_RT;
    mem_to_reg_s = M2R_ALUOUT;
    case (state_r)
      ST_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = SRCB_FOUR;
        ir_write_s  = mem_ready;
        pc_write_s  = mem_ready;
      end
      ST_DECODE: alu_src_b_s = SRCB_IMMSH;
      ST_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = SRCB_IMM;
      end
      ST_MEMRD, ST_JMRD: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b1;
      end
      ST_MEMWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = M2R_MDR;
      end
      ST_MEMWR: begin
        mem_write_s = 1'b1;
        iord_s      = 1'b1;
      end
      ST_RCALC: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = ALUOP_FUNCT;
      end
      ST_RWB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = RDST_RD;
      end
      ST_JMWB: begin
        pc_write_s   = 1'b1;
        pc_source_s  = PCS_MDR;
        reg_write_s  = 1'b1;
        reg_dst_s    = RDST_RA;
        mem_to_reg_s = M2R_PC;
      end
      ST_BEQ: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = ALUOP_SUB;
        pc_source_s = PCS_ALUOUT;
        pc_write_s  = flag_z;
      end
      ST_BLEZAL, ST_BALV, ST_JALPC: begin
        alu_src_a_s  = 1'b1;
        alu_op_s     = ALUOP_SUB;
        pc_source_s  = PCS_ALUOUT;
        pc_write_s   = link_s;
        reg_write_s  = link_s;
        reg_dst_s    = RDST_RA;
        mem_to_reg_s = M2R_PC;
      end
      ST_BRV: begin
        pc_source_s = PCS_REGA;
        pc_write_s  = flag_v;
      end
      ST_ICALC: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = SRCB_IMM;
        alu_op_s    = ALUOP_NAND;
      end
      ST_IWB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = RDST_RT;
      end
      ST_ILL:  illegal_s = 1'b1;
      default: illegal_s = 1'b0;
    endcase
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_FETCH;
      cnt_r   <= '0;
    end else begin
      state_r <= next_s;
      if (retire_s) begin
        cnt_r <= cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Strobes are suppressed while reset is held; selects keep their FETCH values.
  assign pc_write    = pc_write_s  & ~reset;
  assign ir_write    = ir_write_s  & ~reset;
  assign mem_read    = mem_read_s  & ~reset;
  assign mem_write   = mem_write_s & ~reset;
  assign reg_write   = reg_write_s & ~reset;
  assign retire      = retire_s    & ~reset;
  assign illegal_op  = illegal_s   & ~reset;
  assign iord        = iord_s;
  assign alu_src_a   = alu_src_a_s;
  assign alu_src_b   = alu_src_b_s;
  assign alu_op      = alu_op_s;
  assign pc_source   = pc_source_s;
  assign reg_dst     = reg_dst_s;
  assign mem_to_reg  = mem_to_reg_s;
  assign retired_cnt = cnt_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: an instruction-level reference
// model predicts latency, strobe counts and selects for each instruction.
module tb_multicycle_control;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_JMXOR = 3, K_BRV = 4, K_BEQ = 5;
  localparam int K_NANDI = 6, K_BLEZAL = 7, K_BALV = 8, K_JALPC = 9, K_ILL = 10;
  localparam int B_PCW = 0, B_IRW = 1, B_MR = 2, B_MW = 3, B_RW = 4, B_IORD = 5;
  localparam int B_ILL = 17, B_RET = 18;

  logic        clk = 1'b0;
  logic        rst0, rst1, sel, mem_ready, flag_z, flag_n, flag_v;
  logic [5:0]  opcode, functcode;
  wire  [18:0] o0, o1;
  wire  [15:0] cnt0;
  wire  [3:0]  cnt1;
  logic [18:0] o;
  logic [15:0] cnt;

  int n_checks, n_fail, exp_cnt, cnt_mask;
  bit ext_cur;

  always #5 clk = ~clk;

  always_comb begin
    o   = sel ? o1 : o0;
    cnt = sel ? {12'd0, cnt1} : cnt0;
  end

  multicycle_control #(.OPW(6), .FNW(6), .EXT_EN(1), .CNTW(16)) dut0 (
    .clk(clk), .reset(rst0), .opcode(opcode), .functcode(functcode),
    .mem_ready(mem_ready), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .pc_write(o0[0]), .ir_write(o0[1]), .mem_read(o0[2]), .mem_write(o0[3]),
    .reg_write(o0[4]), .iord(o0[5]), .alu_src_a(o0[6]), .alu_src_b(o0[8:7]),
    .alu_op(o0[10:9]), .pc_source(o0[12:11]), .reg_dst(o0[14:13]),
    .mem_to_reg(o0[16:15]), .illegal_op(o0[17]), .retire(o0[18]), .retired_cnt(cnt0)
  );

  multicycle_control #(.OPW(6), .FNW(6), .EXT_EN(0), .CNTW(4)) dut1 (
    .clk(clk), .reset(rst1), .opcode(opcode), .functcode(functcode),
    .mem_ready(mem_ready), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .pc_write(o1[0]), .ir_write(o1[1]), .mem_read(o1[2]), .mem_write(o1[3]),
    .reg_write(o1[4]), .iord(o1[5]), .alu_src_a(o1[6]), .alu_src_b(o1[8:7]),
    .alu_op(o1[10:9]), .pc_source(o1[12:11]), .reg_dst(o1[14:13]),
    .mem_to_reg(o1[16:15]), .illegal_op(o1[17]), .retire(o1[18]), .retired_cnt(cnt1)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit ext_kind(input int k);
    return (k == K_JMXOR || k == K_BRV || k == K_NANDI ||
            k == K_BLEZAL || k == K_BALV || k == K_JALPC);
  endfunction

  function automatic logic [5:0] op_of(input int k);
    case (k)
      K_LW:     op_of = 6'b100011;
      K_SW:     op_of = 6'b101011;
      K_BEQ:    op_of = 6'b000100;
      K_NANDI:  op_of = 6'b010000;
      K_BLEZAL: op_of = 6'b100100;
      K_BALV:   op_of = 6'b100000;
      K_JALPC:  op_of = 6'b011111;
      K_R, K_JMXOR, K_BRV: op_of = 6'b000000;
      default: begin
        case ($urandom_range(0, 4))
          0:       op_of = 6'b000010;
          1:       op_of = 6'b000011;
          2:       op_of = 6'b001000;
          3:       op_of = 6'b111111;
          default: op_of = 6'b100001;
        endcase
      end
    endcase
  endfunction

  function automatic logic [5:0] fn_of(input int k);
    if (k == K_JMXOR) fn_of = 6'd34;
    else if (k == K_BRV) fn_of = 6'd20;
    else if (k == K_R) begin
      case ($urandom_range(0, 4))
        0:       fn_of = 6'd32;
        1:       fn_of = 6'd33;
        2:       fn_of = 6'd36;
        3:       fn_of = 6'd37;
        default: fn_of = 6'd42;
      endcase
    end else fn_of = 6'($urandom_range(0, 63));
  endfunction

  // Drive one instruction from its FETCH cycle; the memory answers each
  // request after a chosen number of wait cycles (negative = random 0..3).
  task automatic run_instr(input int kind, input bit z, input bit n, input bit v,
                           input int df, input int dd, input int abort_at);
    int ke, cyc, wl, acc_n, lat, taken, bsrc, rw, dst, m2r, opme;
    int npcw, nrw, nmr, nmw, niord, nirw, nret, nill, last_pcs, last_dst, last_m2r, opm;
    int acc_d[2];
    bit busy, done, rd, wr;
    ke = (!ext_cur && ext_kind(kind)) ? K_ILL : kind;
    opcode = op_of(kind); functcode = fn_of(kind);
    flag_z = z; flag_n = n; flag_v = v;
    cyc = 0; wl = 0; acc_n = 0; busy = 0; done = 0; acc_d[0] = 0; acc_d[1] = 0;
    npcw = 0; nrw = 0; nmr = 0; nmw = 0; niord = 0; nirw = 0; nret = 0; nill = 0;
    last_pcs = 0; last_dst = 0; last_m2r = 0; opm = 0;
    while (!done && cyc < 40) begin
      #1;
      if (o[B_MR] || o[B_MW]) begin
        if (!busy) begin
          busy = 1;
          wl = (acc_n == 0) ? df : dd;
          if (wl < 0) wl = $urandom_range(0, 3);
          if (acc_n < 2) acc_d[acc_n] = wl;
          acc_n++;
        end
        mem_ready = (wl == 0);
        if (wl == 0) busy = 0; else wl--;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (o[B_PCW]) begin npcw++; last_pcs = int'(o[12:11]); end
      if (o[B_RW]) begin nrw++; last_dst = int'(o[14:13]); last_m2r = int'(o[16:15]); end
      if (o[B_MR]) nmr++;
      if (o[B_MW]) nmw++;
      if (o[B_IORD]) niord++;
      if (o[B_IRW]) nirw++;
      if (o[B_RET]) nret++;
      if (o[B_ILL]) nill++;
      opm = opm | (1 << o[10:9]);
      if (cyc == abort_at) begin
        check_eq("pre_reset_mem_read", int'(o[B_MR]), 1);
        if (sel) rst1 = 1'b1; else rst0 = 1'b1;
        #1;
        check_eq("reset_strobes", int'({o[18:17], o[4:0]}), 0);
        check_eq("reset_alu_src_b", int'(o[8:7]), 1);
        check_eq("reset_cnt", int'(cnt), 0);
        @(posedge clk); #1;
        check_eq("reset_hold_mem_read", int'(o[B_MR]), 0);
        if (sel) rst1 = 1'b0; else rst0 = 1'b0;
        exp_cnt = 0;
        return;
      end
      if (o[B_RET] || o[B_ILL]) done = 1;
      cyc++;
      @(posedge clk); #1;
    end
    rd = (ke == K_LW || ke == K_JMXOR);
    wr = (ke == K_SW);
    case (ke)
      K_LW, K_JMXOR:           lat = 5;
      K_SW, K_R, K_NANDI:      lat = 4;
      default:                 lat = 3;
    endcase
    lat = lat + acc_d[0] + ((rd || wr) ? acc_d[1] : 0);
    case (ke)
      K_BEQ:    begin taken = int'(z);     bsrc = 1; end
      K_BLEZAL: begin taken = int'(z | n); bsrc = 1; end
      K_BALV:   begin taken = int'(v);     bsrc = 1; end
      K_JALPC:  begin taken = 1;           bsrc = 1; end
      K_BRV:    begin taken = int'(v);     bsrc = 3; end
      K_JMXOR:  begin taken = 1;           bsrc = 2; end
      default:  begin taken = 0;           bsrc = 0; end
    endcase
    case (ke)
      K_LW:    begin rw = 1; dst = 0; m2r = 1; end
      K_R:     begin rw = 1; dst = 1; m2r = 0; end
      K_NANDI: begin rw = 1; dst = 0; m2r = 0; end
      K_JMXOR: begin rw = 1; dst = 2; m2r = 2; end
      K_BLEZAL, K_BALV, K_JALPC: begin rw = taken; dst = 2; m2r = 2; end
      default: begin rw = 0; dst = 0; m2r = 0; end
    endcase
    case (ke)
      K_R, K_JMXOR:                      opme = 5;
      K_BEQ, K_BLEZAL, K_BALV, K_JALPC:  opme = 3;
      K_NANDI:                           opme = 9;
      default:                           opme = 1;
    endcase
    check_eq("latency", cyc, lat);
    check_eq("mem_read_cycles", nmr, acc_d[0] + 1 + (rd ? acc_d[1] + 1 : 0));
    check_eq("mem_write_cycles", nmw, wr ? acc_d[1] + 1 : 0);
    check_eq("iord_cycles", niord, (rd || wr) ? acc_d[1] + 1 : 0);
    check_eq("ir_write_cycles", nirw, 1);
    check_eq("pc_write_cycles", npcw, 1 + taken);
    if (taken != 0) check_eq("pc_source", last_pcs, bsrc);
    check_eq("reg_write_cycles", nrw, rw);
    if (rw != 0) begin
      check_eq("reg_dst", last_dst, dst);
      check_eq("mem_to_reg", last_m2r, m2r);
    end
    check_eq("retire_pulses", nret, (ke == K_ILL) ? 0 : 1);
    check_eq("illegal_pulses", nill, (ke == K_ILL) ? 1 : 0);
    check_eq("alu_op_set", opm, opme);
    if (ke != K_ILL) exp_cnt = (exp_cnt + 1) & cnt_mask;
    check_eq("retired_cnt", int'(cnt), exp_cnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    sel = 1'b0; rst0 = 1'b1; rst1 = 1'b1;
    opcode = 6'd0; functcode = 6'd0; mem_ready = 1'b0;
    flag_z = 1'b0; flag_n = 1'b0; flag_v = 1'b0;
    ext_cur = 1'b1; cnt_mask = 32'h0000FFFF; exp_cnt = 0;
    @(posedge clk); #1;
    check_eq("reset_strobes", int'({o[18:17], o[4:0]}), 0);
    check_eq("reset_alu_src_b", int'(o[8:7]), 1);
    check_eq("reset_other_selects", int'({o[16:9], o[6:5]}), 0);
    check_eq("reset_cnt", int'(cnt), 0);
    @(posedge clk); #1;
    rst0 = 1'b0;

    run_instr(K_LW,     1'b0, 1'b0, 1'b0, 0, 0, -1);
    run_instr(K_SW,     1'b0, 1'b0, 1'b0, 0, 3, -1);
    run_instr(K_BEQ,    1'b0, 1'b0, 1'b0, 0, 0, -1);
    run_instr(K_BEQ,    1'b1, 1'b0, 1'b0, 0, 0, -1);
    run_instr(K_BALV,   1'b0, 1'b0, 1'b1, 0, 0, -1);
    run_instr(K_JMXOR,  1'b0, 1'b0, 1'b0, 1, 2, -1);
    run_instr(K_BLEZAL, 1'b0, 1'b1, 1'b0, 0, 0, -1);
    run_instr(K_JALPC,  1'b0, 1'b0, 1'b0, 2, 0, -1);
    run_instr(K_BRV,    1'b0, 1'b0, 1'b1, 0, 0, -1);
    run_instr(K_NANDI,  1'b0, 1'b0, 1'b0, 0, 0, -1);
    run_instr(K_ILL,    1'b0, 1'b0, 1'b0, 0, 0, -1);
    run_instr(K_LW,     1'b0, 1'b0, 1'b0, 0, 3, 3);
    run_instr(K_LW,     1'b0, 1'b0, 1'b0, 0, 0, -1);
    repeat (50) begin
      run_instr($urandom_range(0, 10), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1, -1, -1);
    end

    rst0 = 1'b1; sel = 1'b1; ext_cur = 1'b0; cnt_mask = 15; exp_cnt = 0;
    rst1 = 1'b0;
    run_instr(K_BALV, 1'b0, 1'b0, 1'b1, 0, 0, -1);
    repeat (16) run_instr(K_R, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    repeat (24) begin
      run_instr($urandom_range(0, 10), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
